joy_port_poller: RTL and testbench



---
 rtl/joy_poll_pkg.sv | 48 ++++
 rtl/joy_debounce.sv | 64 ++++++
 rtl/joy_port_poller.sv | 187 ++++++++++++++++++
 tb/tb_joy_port_poller.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/joy_poll_pkg.sv
//==============================================================================
// Module   : joy_poll_pkg
// Purpose  : Shared types and helpers for the MC-10 joystick port poller:
//            poll FSM states, state bit positions, byte decode, port-1 offset.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package joy_poll_pkg;

   // Poll sequencer states
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ0 = 3'd1,
      CAP0 = 3'd2,
      REQ1 = 3'd3,
      CAP1 = 3'd4,
      UPD  = 3'd5
   } poll_state_t;

   // Bit positions inside the decoded {fire,up,down,left,right} state
   localparam int FIRE  = 4;
   localparam int UP    = 3;
   localparam int DOWN  = 2;
   localparam int LEFT  = 1;
   localparam int RIGHT = 0;

   // Port 1 sits four bytes above port 0
   localparam logic [15:0] PORT1_OFFSET = 16'h0004;

   // Fixed high bits every well-formed joystick byte carries
   localparam logic [2:0] FRAME_BITS = 3'b111;

   // Active-low byte {~fire,~right,~left,~down,~up} to active-high state
   function automatic logic [4:0] decode_byte(input logic [4:0] b);
      logic [4:0] s;
      s        = 5'd0;
      s[FIRE]  = ~b[4];
      s[UP]    = ~b[0];
      s[DOWN]  = ~b[1];
      s[LEFT]  = ~b[2];
      s[RIGHT] = ~b[3];
      return s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/joy_debounce.sv
//==============================================================================
// Module   : joy_debounce
// Purpose  : Per-port debounce: candidate + saturating 4-bit run count, stable
//            state, and a one-cycle change strobe in the sample cycle.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module joy_debounce
   import joy_poll_pkg::*;
#(
   parameter int DEBOUNCE = 3
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       sample_valid,
   input  logic [4:0] sample,
   output logic [4:0] state,
   output logic       change
);

   localparam logic [3:0] c_deb = 4'(DEBOUNCE);

   logic [4:0] r_cand;
   logic [3:0] r_cnt;
   logic [4:0] r_state;
   logic [4:0] w_cand_next;
   logic [3:0] w_cnt_next;

   // Next candidate/count and the change decision for the incoming sample
   always_comb begin
      w_cand_next = r_cand;
      w_cnt_next  = r_cnt;
      if (sample_valid) begin
         if (sample == r_cand) begin
            w_cnt_next = (r_cnt == 4'd15) ? 4'd15 : r_cnt + 4'd1;
         end else begin
            w_cand_next = sample;
            w_cnt_next  = 4'd1;
         end
      end
      change = sample_valid && (w_cnt_next >= c_deb) && (w_cand_next != r_state);
   end

   // Candidate, count and accepted state registers
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_cand  <= 5'd0;
         r_cnt   <= 4'd0;
         r_state <= 5'd0;
      end else begin
         r_cand <= w_cand_next;
         r_cnt  <= w_cnt_next;
         if (change) begin
            r_state <= w_cand_next;
         end
      end
   end

   assign state = r_state;

endmodule

`default_nettype wire

// File: rtl/joy_port_poller.sv
//==============================================================================
// Module   : joy_port_poller
// Purpose  : Periodically reads both MC-10 joystick bytes over the CPU bus,
//            frames/decodes/debounces them and emits change events over a
//            valid/ready handshake.
// Options  : JOY_POLL_ERRCNT_EN - adds the 8-bit saturating err_count port.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module joy_port_poller
   import joy_poll_pkg::*;
#(
   parameter int          POLL_DIV  = 1024,
   parameter int          DEBOUNCE  = 3,
   parameter logic [15:0] BASE_ADDR = 16'hBF30
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        enable,
   output logic        bus_req,
   input  logic        bus_gnt,
   output logic [15:0] addr,
   input  logic [7:0]  din,
   output logic [4:0]  state0,
   output logic [4:0]  state1,
   output logic        evt_valid,
   input  logic        evt_ready,
   output logic        evt_port,
   output logic [4:0]  evt_state
`ifdef JOY_POLL_ERRCNT_EN
   ,
   output logic [7:0]  err_count
`endif
);

   localparam logic [15:0] c_tick_max = 16'(POLL_DIV - 1);
   localparam logic [15:0] c_addr1    = BASE_ADDR | PORT1_OFFSET;

   poll_state_t r_state, w_next;
   logic [15:0] r_div;
   logic        w_tick;
   logic [7:0]  r_samp0, r_samp1;
   logic        w_upd, w_bad0, w_bad1;
   logic [4:0]  w_dec0, w_dec1;
   logic        w_chg0, w_chg1;
   logic        r_pend0, r_pend1;
   logic [4:0]  r_slot0, r_slot1;
   logic        r_held, r_held_port;
   logic        w_sel, w_accept;

   assign w_tick = enable && (r_div == c_tick_max);

   // Poll interval counter; parked at zero while polling is disabled
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_div <= 16'd0;
      end else if (!enable || (r_div == c_tick_max)) begin
         r_div <= 16'd0;
      end else begin
         r_div <= r_div + 16'd1;
      end
   end

   // Sequencer state register
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state and bus request; a started poll always runs through UPD
   always_comb begin
      w_next  = r_state;
      bus_req = 1'b0;
      addr    = 16'd0;
      case (r_state)
         IDLE: if (w_tick) w_next = REQ0;
         REQ0: begin
            bus_req = 1'b1;
            addr    = BASE_ADDR;
            if (bus_gnt) w_next = CAP0;
         end
         CAP0: w_next = REQ1;
         REQ1: begin
            bus_req = 1'b1;
            addr    = c_addr1;
            if (bus_gnt) w_next = CAP1;
         end
         CAP1: w_next = UPD;
         UPD:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Capture read data in the cycle after each grant
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_samp0 <= 8'd0;
         r_samp1 <= 8'd0;
      end else begin
         if (r_state == CAP0) r_samp0 <= din;
         if (r_state == CAP1) r_samp1 <= din;
      end
   end

   assign w_upd  = (r_state == UPD);
   assign w_bad0 = (r_samp0[7:5] != FRAME_BITS);
   assign w_bad1 = (r_samp1[7:5] != FRAME_BITS);
   assign w_dec0 = decode_byte(r_samp0[4:0]);
   assign w_dec1 = decode_byte(r_samp1[4:0]);

   joy_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb0 (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .sample_valid (w_upd && !w_bad0),
      .sample       (w_dec0),
      .state        (state0),
      .change       (w_chg0)
   );

   joy_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb1 (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .sample_valid (w_upd && !w_bad1),
      .sample       (w_dec1),
      .state        (state1),
      .change       (w_chg1)
   );

   // Presented port is frozen while the consumer stalls, else port 0 wins
   assign w_sel     = r_held ? r_held_port : (~r_pend0 & r_pend1);
   assign evt_valid = r_pend0 | r_pend1;
   assign evt_port  = w_sel;
   assign evt_state = w_sel ? r_slot1 : r_slot0;
   assign w_accept  = evt_valid & evt_ready;

   // Event slots: a fresh change overwrites (coalesces) and beats a same-cycle accept
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_pend0     <= 1'b0;
         r_pend1     <= 1'b0;
         r_slot0     <= 5'd0;
         r_slot1     <= 5'd0;
         r_held      <= 1'b0;
         r_held_port <= 1'b0;
      end else begin
         r_held      <= evt_valid & ~evt_ready;
         r_held_port <= w_sel;
         if (w_chg0) begin
            r_pend0 <= 1'b1;
            r_slot0 <= w_dec0;
         end else if (w_accept && !w_sel) begin
            r_pend0 <= 1'b0;
         end
         if (w_chg1) begin
            r_pend1 <= 1'b1;
            r_slot1 <= w_dec1;
         end else if (w_accept && w_sel) begin
            r_pend1 <= 1'b0;
         end
      end
   end

`ifdef JOY_POLL_ERRCNT_EN
   logic [7:0] r_err;
   logic [8:0] w_err_sum;

   assign w_err_sum = {1'b0, r_err} + {8'd0, w_bad0} + {8'd0, w_bad1};

   // Framing error count, saturating at 255, cleared only by reset
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_err <= 8'd0;
      end else if (w_upd) begin
         r_err <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
      end
   end

   assign err_count = r_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_joy_port_poller.sv
//==============================================================================
// Module   : tb_joy_port_poller
// Purpose  : Self-checking bench for joy_port_poller with a bus responder,
//            a reference debounce model and an event scoreboard.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_joy_port_poller;

   localparam int          POLL_DIV = 16;
   localparam int          DEBOUNCE = 3;
   localparam logic [15:0] ADDR0    = 16'hBF30;
   localparam logic [15:0] ADDR1    = 16'hBF34;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic        bus_req;
   logic        bus_gnt = 1'b0;
   logic [15:0] addr;
   logic [7:0]  din = 8'hFF;
   logic [4:0]  state0, state1;
   logic        evt_valid;
   logic        evt_ready = 1'b0;
   logic        evt_port;
   logic [4:0]  evt_state;
`ifdef JOY_POLL_ERRCNT_EN
   logic [7:0]  err_count;
`endif

   joy_port_poller #(
      .POLL_DIV  (POLL_DIV),
      .DEBOUNCE  (DEBOUNCE),
      .BASE_ADDR (ADDR0)
   ) dut (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .enable    (enable),
      .bus_req   (bus_req),
      .bus_gnt   (bus_gnt),
      .addr      (addr),
      .din       (din),
      .state0    (state0),
      .state1    (state1),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_port  (evt_port),
      .evt_state (evt_state)
`ifdef JOY_POLL_ERRCNT_EN
      ,
      .err_count (err_count)
`endif
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct packed {
      logic       port;
      logic [4:0] st;
   } evt_t;

   int          checks = 0;
   int          failures = 0;
   evt_t        exp_q[$];
   logic [15:0] addr_log[$];

   // Reference model state
   logic [4:0]  m_cand[2];
   logic [4:0]  m_stab[2];
   int          m_cnt[2];
   int          m_err = 0;

   // Responder controls
   logic [7:0]  p_val[2];
   bit          alt0 = 0;
   bit          block1 = 0;
   bit          prev_gnt = 0;
   logic [15:0] prev_addr = 16'd0;
   logic [7:0]  s0 = 8'hFF;
   int          poll_done = 0;
   bit          evt_seen = 0;

   function automatic logic [4:0] tb_decode(input logic [7:0] b);
      return {~b[4], ~b[0], ~b[1], ~b[2], ~b[3]};
   endfunction

   task automatic model_sample(input int p, input logic [7:0] b);
      logic [4:0] d;
      evt_t e;
      if (b[7:5] !== 3'b111) begin
         if (m_err < 255) m_err++;
         return;
      end
      d = tb_decode(b);
      if (d == m_cand[p]) begin
         if (m_cnt[p] < 15) m_cnt[p]++;
      end else begin
         m_cand[p] = d;
         m_cnt[p]  = 1;
      end
      if (m_cnt[p] >= DEBOUNCE && m_cand[p] != m_stab[p]) begin
         m_stab[p] = m_cand[p];
         e.port = (p == 1);
         e.st   = m_cand[p];
         exp_q.push_back(e);
      end
   endtask

   // Bus responder: grants on the falling edge, returns data the next cycle
   always @(negedge clk_sys) begin
      if (!reset_n) begin
         prev_gnt = 0;
         bus_gnt  = 1'b0;
         din      = 8'hFF;
      end else begin
         if (prev_gnt) begin
            if (prev_addr == ADDR0) begin
               din = p_val[0];
               s0  = p_val[0];
               if (alt0) p_val[0] = p_val[0] ^ 8'h10;
            end else begin
               din = p_val[1];
               model_sample(0, s0);
               model_sample(1, p_val[1]);
               poll_done++;
            end
         end else begin
            din = 8'h00;
         end
         prev_gnt = 0;
         if (bus_req && !(block1 && addr == ADDR1)) begin
            bus_gnt   = 1'b1;
            prev_gnt  = 1;
            prev_addr = addr;
            addr_log.push_back(addr);
         end else begin
            bus_gnt = 1'b0;
         end
      end
   end

   // Event monitor: scoreboard pop on accept, stability check while stalled
   bit         h_valid = 0;
   logic       h_port;
   logic [4:0] h_st;
   always @(negedge clk_sys) begin
      int idx;
      if (evt_valid) evt_seen = 1;
      if (reset_n && h_valid) begin
         checks++;
         if ({evt_valid, evt_port, evt_state} !== {1'b1, h_port, h_st}) begin
            failures++;
            $display("FAIL evt_hold got=%b/%0d/%b exp=1/%0d/%b", evt_valid, evt_port, evt_state, h_port, h_st);
         end
      end
      if (reset_n && evt_valid && evt_ready) begin
         idx = -1;
         foreach (exp_q[i]) if (idx < 0 && exp_q[i].port == evt_port) idx = i;
         checks++;
         if (idx < 0) begin
            failures++;
            $display("FAIL evt_unexpected got port=%0d state=%b exp=none", evt_port, evt_state);
         end else begin
            if (exp_q[idx].st !== evt_state) begin
               failures++;
               $display("FAIL evt_state port=%0d got=%b exp=%b", evt_port, evt_state, exp_q[idx].st);
            end
            exp_q.delete(idx);
         end
      end
      h_valid = reset_n && evt_valid && !evt_ready;
      h_port  = evt_port;
      h_st    = evt_state;
   end

   task automatic wait_polls(input int n);
      int target;
      int cyc;
      target = poll_done + n;
      cyc = 0;
      while (poll_done < target && cyc < 100 * n) begin
         @(posedge clk_sys);
         cyc++;
      end
      if (poll_done < target) begin
         checks++;
         failures++;
         $display("FAIL poll_timeout got=%0d exp=%0d", poll_done, target);
      end
      repeat (2) @(posedge clk_sys);
      #1;
   endtask

   task automatic accept_one();
      evt_ready = 1'b1;
      @(posedge clk_sys);
      #1;
      evt_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      enable  = 1'b0;
      repeat (3) @(posedge clk_sys);
      #1;
      checks++; if (bus_req !== 1'b0)   begin failures++; $display("FAIL rst_bus_req got=%b exp=0", bus_req); end
      checks++; if (addr !== 16'h0)     begin failures++; $display("FAIL rst_addr got=%h exp=0000", addr); end
      checks++; if (state0 !== 5'd0)    begin failures++; $display("FAIL rst_state0 got=%b exp=00000", state0); end
      checks++; if (state1 !== 5'd0)    begin failures++; $display("FAIL rst_state1 got=%b exp=00000", state1); end
      checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL rst_evt_valid got=%b exp=0", evt_valid); end
      checks++; if (evt_port !== 1'b0)  begin failures++; $display("FAIL rst_evt_port got=%b exp=0", evt_port); end
      checks++; if (evt_state !== 5'd0) begin failures++; $display("FAIL rst_evt_state got=%b exp=00000", evt_state); end
`ifdef JOY_POLL_ERRCNT_EN
      checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL rst_err_count got=%0d exp=0", err_count); end
`endif
      reset_n = 1'b1;
      repeat (2) @(posedge clk_sys);
      #1;
      checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL idle_bus_req got=%b exp=0", bus_req); end
   endtask

   task automatic test_idle_ff();
      p_val[0] = 8'hFF;
      p_val[1] = 8'hFF;
      addr_log.delete();
      evt_seen = 0;
      enable = 1'b1;
      wait_polls(3);
      checks++;
      if (addr_log.size() < 2 || addr_log[0] !== ADDR0 || addr_log[1] !== ADDR1) begin
         failures++;
         $display("FAIL addr_seq got=%h,%h exp=%h,%h", (addr_log.size() > 0) ? addr_log[0] : 16'h0,
                  (addr_log.size() > 1) ? addr_log[1] : 16'h0, ADDR0, ADDR1);
      end
      checks++; if (state0 !== 5'd0) begin failures++; $display("FAIL ff_state0 got=%b exp=00000", state0); end
      checks++; if (state1 !== 5'd0) begin failures++; $display("FAIL ff_state1 got=%b exp=00000", state1); end
      checks++; if (evt_seen !== 1'b0) begin failures++; $display("FAIL ff_no_event got=%b exp=0", evt_seen); end
   endtask

   task automatic test_fire();
      evt_ready = 1'b0;
      p_val[0] = 8'hEF;
      wait_polls(2);
      checks++; if (state0 !== 5'd0) begin failures++; $display("FAIL fire_early_state0 got=%b exp=00000", state0); end
      checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL fire_early_valid got=%b exp=0", evt_valid); end
      wait_polls(1);
      checks++; if (state0 !== 5'b10000) begin failures++; $display("FAIL fire_state0 got=%b exp=10000", state0); end
      checks++; if (evt_valid !== 1'b1) begin failures++; $display("FAIL fire_evt_valid got=%b exp=1", evt_valid); end
      checks++; if (evt_port !== 1'b0) begin failures++; $display("FAIL fire_evt_port got=%b exp=0", evt_port); end
      checks++; if (evt_state !== 5'b10000) begin failures++; $display("FAIL fire_evt_state got=%b exp=10000", evt_state); end
   endtask

   task automatic test_priority();
      p_val[1] = 8'hFE;
      wait_polls(3);
      checks++; if (state1 !== 5'b01000) begin failures++; $display("FAIL prio_state1 got=%b exp=01000", state1); end
      checks++; if (evt_port !== 1'b0 || evt_state !== 5'b10000) begin
         failures++; $display("FAIL prio_first got=%0d/%b exp=0/10000", evt_port, evt_state); end
      accept_one();
      checks++; if (evt_valid !== 1'b1 || evt_port !== 1'b1 || evt_state !== 5'b01000) begin
         failures++; $display("FAIL prio_second got=%b/%0d/%b exp=1/1/01000", evt_valid, evt_port, evt_state); end
      accept_one();
      checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL prio_drained got=%b exp=0", evt_valid); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL prio_scoreboard got=%0d exp=0", exp_q.size()); end
   endtask

   task automatic test_alternate();
      evt_seen = 0;
      p_val[0] = 8'hFF;
      alt0 = 1;
      wait_polls(6);
      alt0 = 0;
      p_val[0] = 8'hEF;
      wait_polls(1);
      checks++; if (state0 !== 5'b10000) begin failures++; $display("FAIL alt_state0 got=%b exp=10000", state0); end
      checks++; if (evt_seen !== 1'b0) begin failures++; $display("FAIL alt_no_event got=%b exp=0", evt_seen); end
   endtask

   task automatic test_framing();
      evt_seen = 0;
      p_val[0] = 8'h0F;
      wait_polls(1);
      p_val[0] = 8'hEF;
      checks++; if (state0 !== 5'b10000) begin failures++; $display("FAIL frame_state0 got=%b exp=10000", state0); end
      checks++; if (evt_seen !== 1'b0) begin failures++; $display("FAIL frame_no_event got=%b exp=0", evt_seen); end
`ifdef JOY_POLL_ERRCNT_EN
      checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL frame_err_count got=%0d exp=1", err_count); end
`endif
      wait_polls(1);
      checks++; if (state0 !== m_stab[0] || state1 !== m_stab[1]) begin
         failures++; $display("FAIL frame_model got=%b/%b exp=%b/%b", state0, state1, m_stab[0], m_stab[1]); end
`ifdef JOY_POLL_ERRCNT_EN
      checks++; if (err_count !== 8'(m_err)) begin failures++; $display("FAIL frame_err_model got=%0d exp=%0d", err_count, m_err); end
`endif
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL frame_scoreboard got=%0d exp=0", exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      int cyc;
      block1 = 1;
      cyc = 0;
      while (!(bus_req === 1'b1 && addr === ADDR1) && cyc < 200) begin
         @(posedge clk_sys);
         #1;
         cyc++;
      end
      repeat (3) @(posedge clk_sys);
      #1;
      checks++; if (bus_req !== 1'b1 || addr !== ADDR1) begin
         failures++; $display("FAIL req1_wait got=%b/%h exp=1/%h", bus_req, addr, ADDR1); end
      #1;
      reset_n = 1'b0;
      #1;
      checks++; if (bus_req !== 1'b0)   begin failures++; $display("FAIL arst_bus_req got=%b exp=0", bus_req); end
      checks++; if (addr !== 16'h0)     begin failures++; $display("FAIL arst_addr got=%h exp=0000", addr); end
      checks++; if (state0 !== 5'd0 || state1 !== 5'd0) begin
         failures++; $display("FAIL arst_states got=%b/%b exp=00000/00000", state0, state1); end
      checks++; if (evt_valid !== 1'b0 || evt_port !== 1'b0 || evt_state !== 5'd0) begin
         failures++; $display("FAIL arst_evt got=%b/%b/%b exp=0/0/00000", evt_valid, evt_port, evt_state); end
`ifdef JOY_POLL_ERRCNT_EN
      checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL arst_err_count got=%0d exp=0", err_count); end
`endif
      block1 = 0;
      repeat (2) @(posedge clk_sys);
   endtask

   initial begin
      for (int p = 0; p < 2; p++) begin
         m_cand[p] = 5'd0;
         m_stab[p] = 5'd0;
         m_cnt[p]  = 0;
         p_val[p]  = 8'hFF;
      end
      test_reset();
      test_idle_ff();
      test_fire();
      test_priority();
      test_alternate();
      test_framing();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
